addacc_dro_sched: RTL and testbench

//  Clocked scheduler sharing one DRO storage cell (addacc datapath) among N_REQ requesters.

---
 rtl/addacc_dro_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_addacc_dro_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addacc_dro_sched.sv
// addacc_dro_sched
//   Round-robin scheduler that shares one DRO storage cell among N_REQ
//   requesters. The granted operand is pushed through the cell one bit at a
//   time, LSB first. The result word comes back tagged with the requester id.
//
//   Every output is a register. Each output is therefore visible one cycle
//   after the FSM state that produces it. The dro_out input is sampled in
//   real time while the FSM is in SAMPLE. That state falls exactly T_DELAY
//   cycles after the visible dro_clk pulse.
//
//   Optional monitor: define ADDACC_SCHED_CHECK_EN to let warn flag dro_out
//   activity outside SAMPLE, and unknown dro_out inside SAMPLE.
//   With the macro undefined, warn is tied low and no monitor logic exists.

module addacc_dro_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int W       = 8,
  parameter int T_SETUP = 8,
  parameter int T_DELAY = 13,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               dro_d,
  output logic               dro_clk,
  input  logic               dro_out,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               warn
);

  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETUP  = 3'd2,
    FIRE   = 3'd3,
    FLIGHT = 3'd4,
    SAMPLE = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t             state_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    id_r;
  logic [W-1:0]       operand_r;
  logic [W-1:0]       result_r;
  logic [BIT_W-1:0]   bit_idx_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [N_REQ-1:0]   gnt_r;
  logic               busy_r;
  logic               dro_d_r;
  logic               dro_clk_r;
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [W-1:0]       rsp_data_r;

  logic               grant_vld_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [N_REQ-1:0]   grant_onehot_s;

  // Round-robin pick: first set request at or after rr_ptr, wrapping around
  always_comb begin
    int idx;
    grant_vld_s    = 1'b0;
    grant_idx_s    = {ID_W{1'b0}};
    grant_onehot_s = {N_REQ{1'b0}};
    idx            = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_r) + i) % N_REQ;
      if (!grant_vld_s && req[idx]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = ID_W'(idx);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vld_s && (grant_idx_s == ID_W'(i))) begin
        grant_onehot_s[i] = 1'b1;
      end else begin
        grant_onehot_s[i] = 1'b0;
      end
    end
  end

  // Scheduler FSM with registered outputs: arbitrate, then drive/setup/fire/flight/sample per bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {ID_W{1'b0}};
      id_r        <= {ID_W{1'b0}};
      operand_r   <= {W{1'b0}};
      result_r    <= {W{1'b0}};
      bit_idx_r   <= {BIT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      gnt_r       <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
      dro_d_r     <= 1'b0;
      dro_clk_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_data_r  <= {W{1'b0}};
    end else begin
      // Pulse outputs default low. busy mirrors "not IDLE", delayed one cycle like every output.
      gnt_r       <= {N_REQ{1'b0}};
      dro_d_r     <= 1'b0;
      dro_clk_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= (state_r != IDLE);

      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            gnt_r     <= grant_onehot_s;
            operand_r <= req_data[int'(grant_idx_s)*W +: W];
            id_r      <= grant_idx_s;
            if (grant_idx_s == ID_W'(N_REQ - 1)) begin
              rr_ptr_r <= {ID_W{1'b0}};
            end else begin
              rr_ptr_r <= grant_idx_s + ID_W'(1);
            end
            bit_idx_r <= {BIT_W{1'b0}};
            state_r   <= DRIVE;
          end else begin
            state_r <= IDLE;
          end
        end

        DRIVE: begin
          // A zero bit simply produces no pulse on the cell data line
          dro_d_r <= operand_r[bit_idx_r];
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= SETUP;
        end

        SETUP: begin
          if (cnt_r == CNT_W'(T_SETUP - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= FIRE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        FIRE: begin
          dro_clk_r <= 1'b1;
          cnt_r     <= {CNT_W{1'b0}};
          state_r   <= FLIGHT;
        end

        FLIGHT: begin
          if (cnt_r == CNT_W'(T_DELAY - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        SAMPLE: begin
          // Captured as-is; an unknown cell output propagates into the result
          result_r[bit_idx_r] <= dro_out;
          if (bit_idx_r == BIT_W'(W - 1)) begin
            state_r <= DONE;
          end else begin
            bit_idx_r <= bit_idx_r + BIT_W'(1);
            state_r   <= DRIVE;
          end
        end

        DONE: begin
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= result_r;
          rsp_id_r    <= id_r;
          bit_idx_r   <= {BIT_W{1'b0}};
          state_r     <= IDLE;
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign dro_d     = dro_d_r;
  assign dro_clk   = dro_clk_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;

`ifdef ADDACC_SCHED_CHECK_EN
  logic warn_r;

  // Cell monitor: output high outside SAMPLE, or unknown inside SAMPLE, raises a one-cycle warning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warn_r <= 1'b0;
    end else begin
      warn_r <= ((state_r != SAMPLE) && (dro_out === 1'b1)) ||
                ((state_r == SAMPLE) && (dro_out !== 1'b0) && (dro_out !== 1'b1));
    end
  end

  assign warn = warn_r;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_addacc_dro_sched.sv
// Directed bench for addacc_dro_sched at default parameters.
// The cell model returns out=1 exactly T_DELAY cycles after a dro_clk pulse,
// provided dro_d was pulsed since the previous dro_clk. The model can be
// forced high, or held stuck at 0.
module tb_addacc_dro_sched;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int W       = 8;
  localparam int T_SETUP = 8;
  localparam int T_DELAY = 13;
  localparam int CNT_W   = 5;
  localparam int LAT     = W * (T_SETUP + T_DELAY + 3) + 1;  // 193

`ifdef ADDACC_SCHED_CHECK_EN
  localparam logic EXP_WARN = 1'b1;
`else
  localparam logic EXP_WARN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*W-1:0] req_data = '0;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               dro_d;
  logic               dro_clk;
  logic               dro_out = 1'b0;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_data;
  logic               warn;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // cell model state and pulse statistics
  logic force_one = 1'b0;
  logic stuck     = 1'b0;
  logic armed     = 1'b0;
  int   fire_at   = -1;
  int   nd = 0, nc = 0, last_d = 0, sp_bad = 0, sp_n = 0, overlap = 0;

  addacc_dro_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .W(W),
    .T_SETUP(T_SETUP), .T_DELAY(T_DELAY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .dro_d(dro_d), .dro_clk(dro_clk),
    .dro_out(dro_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .warn(warn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cell model and pulse bookkeeping, evaluated mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      armed   = 1'b0;
      fire_at = -1;
    end else begin
      if (dro_d && dro_clk) overlap++;
      if (dro_d) begin
        nd++;
        last_d = cyc;
        armed  = 1'b1;
      end
      if (dro_clk) begin
        nc++;
        sp_n++;
        if (cyc - last_d != T_SETUP + 1) sp_bad++;
        if (armed && !stuck) fire_at = cyc + T_DELAY;
        armed = 1'b0;
      end
    end
    dro_out <= force_one || (cyc == fire_at);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, output int at);
    int n = 0;
    do begin tick(); n++; end while (gnt === '0 && n < 300);
    check({tag, "_gnt_timeout"}, 32'(gnt !== '0), 32'd1);
    at = cyc;
  endtask

  task automatic wait_rsp(input string tag, output int at);
    int n = 0;
    do begin tick(); n++; end while (rsp_valid !== 1'b1 && n < 300);
    check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    at = cyc;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int g, r, rprev;
    logic [3:0] eg;

    // ---- reset state
    tick(); tick();
    check("reset_outputs", 32'({gnt, busy, dro_d, dro_clk, rsp_valid, rsp_id, rsp_data, warn}), 32'd0);
    rst = 1'b0;

    // ---- T1: single requester 2, operand A5
    nd = 0; nc = 0;
    req_data[2*W +: W] = 8'hA5;
    req = 4'b0100;
    wait_gnt("t1", g);
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_busy_at_gnt", 32'(busy), 32'd0);
    req = 4'b0000;
    tick();
    check("t1_busy_after_gnt", 32'(busy), 32'd1);
    check("t1_gnt_one_cycle", 32'(gnt), 32'd0);
    wait_rsp("t1", r);
    check("t1_latency", 32'(r - g), 32'(LAT));
    check("t1_rsp_id", 32'(rsp_id), 32'd2);
    check("t1_rsp_data", 32'(rsp_data), 32'hA5);
    check("t1_busy_at_rsp", 32'(busy), 32'd1);
    check("t1_d_pulses", 32'(nd), 32'd4);
    check("t1_clk_pulses", 32'(nc), 32'd8);
    tick();
    check("t1_rsp_one_cycle", 32'({rsp_valid, busy}), 32'd0);
    check("t1_rsp_held", 32'(rsp_data), 32'hA5);

    // ---- T3: pointer is 3 after serving 2; req 1001 -> 3 then 0
    req_data[3*W +: W] = 8'h3C;
    req_data[0*W +: W] = 8'hC3;
    req = 4'b1001;
    wait_gnt("t3a", g);
    check("t3_first_gnt", 32'(gnt), 32'h8);
    req = 4'b0001;
    wait_rsp("t3a", r);
    check("t3a_rsp_id", 32'(rsp_id), 32'd3);
    check("t3a_rsp_data", 32'(rsp_data), 32'h3C);
    wait_gnt("t3b", g);
    check("t3_second_gnt", 32'(gnt), 32'h1);
    check("t3_gnt_after_done", 32'(g - r), 32'd1);
    req = 4'b0000;
    wait_rsp("t3b", r);
    check("t3b_rsp_id", 32'(rsp_id), 32'd0);
    check("t3b_rsp_data", 32'(rsp_data), 32'hC3);

    // ---- T2: fresh pointer, all four requesting zero operands
    pulse_rst();
    nd = 0;
    req_data = '0;
    req = 4'b1111;
    rprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("t2", g);
      eg = 4'b0001 << (k % 4);
      check("t2_gnt_order", 32'(gnt), 32'(eg));
      if (k > 0) check("t2_gnt_after_done", 32'(g - rprev), 32'd1);
      if (k == 4) req = 4'b0000;
      wait_rsp("t2", r);
      rprev = r;
      check("t2_rsp_id", 32'(rsp_id), 32'(k % 4));
      check("t2_rsp_data", 32'(rsp_data), 32'd0);
    end
    check("t2_no_d_pulses", 32'(nd), 32'd0);

    // ---- T4: reset during bit 3 FLIGHT
    req_data[2*W +: W] = 8'h5A;
    req = 4'b0100;
    wait_gnt("t4", g);
    req = 4'b0000;
    repeat (85) tick();
    check("t4_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t4_outputs_zero", 32'({gnt, busy, dro_d, dro_clk, rsp_valid, rsp_id, rsp_data, warn}), 32'd0);
    req_data[0*W +: W] = 8'h81;
    req = 4'b0001;
    tick();
    rst = 1'b0;
    tick();
    check("t4_gnt_first_cycle", 32'(gnt), 32'h1);
    g = cyc;
    req = 4'b0000;
    wait_rsp("t4", r);
    check("t4_latency", 32'(r - g), 32'(LAT));
    check("t4_rsp_data", 32'(rsp_data), 32'h81);

    // ---- T5: spurious cell output during SETUP
    req_data[1*W +: W] = 8'h96;
    req = 4'b0010;
    wait_gnt("t5", g);
    check("t5_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick(); tick();
    force_one = 1'b1;
    check("t5_warn_before", 32'(warn), 32'd0);
    tick();
    force_one = 1'b0;
    check("t5_warn_pulse", 32'(warn), 32'(EXP_WARN));
    tick();
    check("t5_warn_one_cycle", 32'(warn), 32'd0);
    wait_rsp("t5", r);
    check("t5_rsp_data", 32'(rsp_data), 32'h96);

    // ---- T6: all-ones operand, cell stuck at 0
    stuck = 1'b1;
    nd = 0; nc = 0; sp_bad = 0; sp_n = 0; overlap = 0;
    req_data[3*W +: W] = 8'hFF;
    req = 4'b1000;
    wait_gnt("t6", g);
    check("t6_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    wait_rsp("t6", r);
    check("t6_rsp_data", 32'(rsp_data), 32'h00);
    check("t6_d_pulses", 32'(nd), 32'd8);
    check("t6_clk_pulses", 32'(nc), 32'd8);
    check("t6_spacing_samples", 32'(sp_n), 32'd8);
    check("t6_spacing_bad", 32'(sp_bad), 32'd0);
    check("t6_no_overlap", 32'(overlap), 32'd0);
    stuck = 1'b0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
